// File: rtl/trap_pkg.sv
// Shared definitions for the machine-mode trap sequencer: FSM states, CSR addresses, causes, mstatus fields.
// Build option: define TRAP_VECTORED_EN to vector interrupts when mtvec mode bits are 01.
package trap_pkg;

    localparam int XLEN = 32;

`ifdef TRAP_VECTORED_EN
    localparam bit TRAP_VECTORED = 1'b1;
`else
    localparam bit TRAP_VECTORED = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_W_MEPC   = 3'd1,
        ST_W_MCAUSE = 3'd2,
        ST_W_MSTAT  = 3'd3,
        ST_W_RET    = 3'd4,
        ST_REDIR    = 3'd5
    } trap_state_t;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [XLEN-1:0] CAUSE_ILLEGAL     = 32'h0000_0002;
    localparam logic [XLEN-1:0] CAUSE_EBREAK      = 32'h0000_0003;
    localparam logic [XLEN-1:0] CAUSE_ECALL       = 32'h0000_000B;
    localparam logic [XLEN-1:0] CAUSE_M_EXT_IRQ   = 32'h8000_000B;
    localparam logic [XLEN-1:0] CAUSE_M_TIMER_IRQ = 32'h8000_0007;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;
    localparam int MIE_MTIE       = 7;
    localparam int MIE_MEIE       = 11;

    function automatic logic [XLEN-1:0] mstatus_on_trap(input logic [XLEN-1:0] ms);
        logic [XLEN-1:0] res;
        res = ms;
        res[MSTATUS_MPIE] = ms[MSTATUS_MIE];
        res[MSTATUS_MIE]  = 1'b0;
        res[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return res;
    endfunction

    function automatic logic [XLEN-1:0] mstatus_on_mret(input logic [XLEN-1:0] ms);
        logic [XLEN-1:0] res;
        res = ms;
        res[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
        res[MSTATUS_MPIE] = 1'b1;
        return res;
    endfunction

    // Exceptions always land on the base; only interrupts honour vectored mode.
    function automatic logic [XLEN-1:0] trap_target(input logic [XLEN-1:0] mtvec,
                                                    input logic [4:0]      cause_code,
                                                    input logic            is_irq);
        logic [XLEN-1:0] res;
        res = {mtvec[XLEN-1:2], 2'b00};
        if (TRAP_VECTORED && is_irq && (mtvec[1:0] == 2'b01))
            res = res + {{(XLEN-7){1'b0}}, cause_code, 2'b00};
        return res;
    endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Commit-stage / CSR-side bundle of the trap sequencer; slave is the sequencer, master the surrounding core.
interface trap_ctrl_if;

    logic                      i_valid;
    logic [trap_pkg::XLEN-1:0] i_pc;
    logic                      i_is_ecall;
    logic                      i_is_ebreak;
    logic                      i_illegal;
    logic                      i_is_mret;
    logic                      irq_ext;
    logic                      irq_timer;
    logic [trap_pkg::XLEN-1:0] mstatus_in;
    logic [trap_pkg::XLEN-1:0] mie_in;
    logic [trap_pkg::XLEN-1:0] mtvec_in;
    logic [trap_pkg::XLEN-1:0] mepc_in;

    logic                      csr_wr_en;
    logic [11:0]               csr_addr;
    logic [trap_pkg::XLEN-1:0] csr_wr_data;
    logic                      stall;
    logic                      flush;
    logic                      redirect_valid;
    logic [trap_pkg::XLEN-1:0] redirect_pc;
    logic                      trap_detected;

    modport master (
        output i_valid, i_pc, i_is_ecall, i_is_ebreak, i_illegal, i_is_mret,
        output irq_ext, irq_timer, mstatus_in, mie_in, mtvec_in, mepc_in,
        input  csr_wr_en, csr_addr, csr_wr_data, stall, flush,
        input  redirect_valid, redirect_pc, trap_detected
    );

    modport slave (
        input  i_valid, i_pc, i_is_ecall, i_is_ebreak, i_illegal, i_is_mret,
        input  irq_ext, irq_timer, mstatus_in, mie_in, mtvec_in, mepc_in,
        output csr_wr_en, csr_addr, csr_wr_data, stall, flush,
        output redirect_valid, redirect_pc, trap_detected
    );

endinterface

// File: rtl/trap_prio.sv
// Combinational event selector: picks the highest-priority exception, mret or enabled interrupt.
module trap_prio
    import trap_pkg::*;
(
    input  logic            i_valid,
    input  logic            i_is_ecall,
    input  logic            i_is_ebreak,
    input  logic            i_illegal,
    input  logic            i_is_mret,
    input  logic            i_irq_ext,
    input  logic            i_irq_timer,
    input  logic            i_mstatus_mie,
    input  logic            i_mie_meie,
    input  logic            i_mie_mtie,
    output logic            o_take,
    output logic            o_is_mret,
    output logic            o_is_irq,
    output logic [XLEN-1:0] o_cause
);

    // Illegal outranks mret, so a malformed mret traps instead of returning.
    always_comb begin
        o_take    = 1'b0;
        o_is_mret = 1'b0;
        o_is_irq  = 1'b0;
        o_cause   = '0;
        if (i_valid) begin
            if (i_illegal) begin
                o_take  = 1'b1;
                o_cause = CAUSE_ILLEGAL;
            end else if (i_is_ebreak) begin
                o_take  = 1'b1;
                o_cause = CAUSE_EBREAK;
            end else if (i_is_ecall) begin
                o_take  = 1'b1;
                o_cause = CAUSE_ECALL;
            end else if (i_is_mret) begin
                o_take    = 1'b1;
                o_is_mret = 1'b1;
            end else if (i_mstatus_mie && i_irq_ext && i_mie_meie) begin
                o_take   = 1'b1;
                o_is_irq = 1'b1;
                o_cause  = CAUSE_M_EXT_IRQ;
            end else if (i_mstatus_mie && i_irq_timer && i_mie_mtie) begin
                o_take   = 1'b1;
                o_is_irq = 1'b1;
                o_cause  = CAUSE_M_TIMER_IRQ;
            end
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: drives mepc/mcause/mstatus writes or the mret update, then redirects fetch.
// Build option: TRAP_VECTORED_EN (see trap_pkg) enables vectored interrupt targets.
module trap_ctrl
    import trap_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    trap_ctrl_if.slave  bus
);

    logic            w_take;
    logic            w_is_mret;
    logic            w_is_irq;
    logic [XLEN-1:0] w_cause;
    logic            w_accept;
    logic            w_busy_stall;

    trap_state_t     r_state;
    logic [XLEN-1:0] r_cause;
    logic [XLEN-1:0] r_target;
    logic            r_csr_wr_en;
    logic [11:0]     r_csr_addr;
    logic [XLEN-1:0] r_csr_wr_data;
    logic            r_flush;
    logic            r_trap_detected;
    logic            r_redirect_valid;
    logic [XLEN-1:0] r_redirect_pc;

    trap_prio u_prio (
        .i_valid       (bus.i_valid),
        .i_is_ecall    (bus.i_is_ecall),
        .i_is_ebreak   (bus.i_is_ebreak),
        .i_illegal     (bus.i_illegal),
        .i_is_mret     (bus.i_is_mret),
        .i_irq_ext     (bus.irq_ext),
        .i_irq_timer   (bus.irq_timer),
        .i_mstatus_mie (bus.mstatus_in[MSTATUS_MIE]),
        .i_mie_meie    (bus.mie_in[MIE_MEIE]),
        .i_mie_mtie    (bus.mie_in[MIE_MTIE]),
        .o_take        (w_take),
        .o_is_mret     (w_is_mret),
        .o_is_irq      (w_is_irq),
        .o_cause       (w_cause)
    );

    assign w_accept     = (r_state == ST_IDLE) && w_take;
    assign w_busy_stall = (r_state == ST_W_MEPC) || (r_state == ST_W_MCAUSE) ||
                          (r_state == ST_W_MSTAT) || (r_state == ST_W_RET);

    // Stall is the only combinational output; gating by rst keeps it low while held in reset.
    assign bus.stall          = rst & (w_accept | w_busy_stall);
    assign bus.csr_wr_en      = r_csr_wr_en;
    assign bus.csr_addr       = r_csr_addr;
    assign bus.csr_wr_data    = r_csr_wr_data;
    assign bus.flush          = r_flush;
    assign bus.trap_detected  = r_trap_detected;
    assign bus.redirect_valid = r_redirect_valid;
    assign bus.redirect_pc    = r_redirect_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state          <= ST_IDLE;
            r_cause          <= '0;
            r_target         <= '0;
            r_csr_wr_en      <= 1'b0;
            r_csr_addr       <= '0;
            r_csr_wr_data    <= '0;
            r_flush          <= 1'b0;
            r_trap_detected  <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_csr_wr_en      <= 1'b0;
            r_csr_addr       <= '0;
            r_csr_wr_data    <= '0;
            r_flush          <= 1'b0;
            r_trap_detected  <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_flush     <= 1'b1;
                        r_csr_wr_en <= 1'b1;
                        if (w_is_mret) begin
                            r_state       <= ST_W_RET;
                            r_target      <= bus.mepc_in;
                            r_csr_addr    <= CSR_MSTATUS;
                            r_csr_wr_data <= mstatus_on_mret(bus.mstatus_in);
                        end else begin
                            r_state         <= ST_W_MEPC;
                            r_cause         <= w_cause;
                            r_target        <= trap_target(bus.mtvec_in, w_cause[4:0], w_is_irq);
                            r_trap_detected <= 1'b1;
                            r_csr_addr      <= CSR_MEPC;
                            r_csr_wr_data   <= bus.i_pc;
                        end
                    end
                end
                ST_W_MEPC: begin
                    r_state       <= ST_W_MCAUSE;
                    r_csr_wr_en   <= 1'b1;
                    r_csr_addr    <= CSR_MCAUSE;
                    r_csr_wr_data <= r_cause;
                end
                ST_W_MCAUSE: begin
                    r_state       <= ST_W_MSTAT;
                    r_csr_wr_en   <= 1'b1;
                    r_csr_addr    <= CSR_MSTATUS;
                    r_csr_wr_data <= mstatus_on_trap(bus.mstatus_in);
                end
                ST_W_MSTAT, ST_W_RET: begin
                    r_state          <= ST_REDIR;
                    r_redirect_valid <= 1'b1;
                    r_redirect_pc    <= r_target;
                end
                ST_REDIR: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: directed scenarios plus randomized commit traffic against a queue-based model.
module tb_trap_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    trap_ctrl_if bus();

    trap_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct { int cyc; logic [11:0] addr; logic [31:0] data; } wr_t;
    typedef struct { int cyc; logic [31:0] pc; } rd_t;
    typedef struct { int cyc; logic trap; } fl_t;

    wr_t wr_q[$];
    rd_t rd_q[$];
    fl_t fl_q[$];
    wr_t m_wr;
    rd_t m_rd;
    fl_t m_fl;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int busy  = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] m_trap_ms(input logic [31:0] ms);
        return (ms & ~32'h0000_1888) | 32'h0000_1800 | (((ms >> 3) & 32'h1) << 7);
    endfunction

    function automatic logic [31:0] m_ret_ms(input logic [31:0] ms);
        return (ms & ~32'h0000_0008) | (((ms >> 7) & 32'h1) << 3) | 32'h0000_0080;
    endfunction

    // One cycle of stimulus: if the sequencer is idle, decide the event from the rules and queue its effects.
    task automatic step();
        int          kind;
        logic [31:0] cause;
        logic [31:0] tgt;
        logic [31:0] ms;
        logic        exp_stall;
        kind      = 0;
        cause     = 32'h0;
        exp_stall = (busy > 1);
        if (busy == 0) begin
            ms = bus.mstatus_in;
            if (bus.i_valid && bus.i_illegal)            begin kind = 1; cause = 2; end
            else if (bus.i_valid && bus.i_is_ebreak)     begin kind = 1; cause = 3; end
            else if (bus.i_valid && bus.i_is_ecall)      begin kind = 1; cause = 11; end
            else if (bus.i_valid && bus.i_is_mret)       begin kind = 2; end
            else if (bus.i_valid && ms[3] && bus.irq_ext && bus.mie_in[11])   begin kind = 3; cause = 32'h8000000B; end
            else if (bus.i_valid && ms[3] && bus.irq_timer && bus.mie_in[7])  begin kind = 3; cause = 32'h80000007; end
            if (kind != 0) exp_stall = 1'b1;
            if (kind == 2) begin
                wr_q.push_back('{cyc + 1, 12'h300, m_ret_ms(ms)});
                fl_q.push_back('{cyc + 1, 1'b0});
                rd_q.push_back('{cyc + 2, bus.mepc_in});
            end else if (kind != 0) begin
                tgt = bus.mtvec_in & ~32'h3;
`ifdef TRAP_VECTORED_EN
                if (kind == 3 && bus.mtvec_in[1:0] == 2'b01) tgt = tgt + 4 * (cause & 32'h1F);
`endif
                wr_q.push_back('{cyc + 1, 12'h341, bus.i_pc});
                wr_q.push_back('{cyc + 2, 12'h342, cause});
                wr_q.push_back('{cyc + 3, 12'h300, m_trap_ms(ms)});
                fl_q.push_back('{cyc + 1, 1'b1});
                rd_q.push_back('{cyc + 4, tgt});
            end
        end
        @(negedge clk);
        chk("stall", {31'b0, bus.stall}, {31'b0, exp_stall});
        @(posedge clk);
        #1;
        if (kind == 2)      busy = 2;
        else if (kind != 0) busy = 4;
        else if (busy > 0)  busy--;
    endtask

    task automatic clear_flags();
        bus.i_valid     = 1'b0;
        bus.i_is_ecall  = 1'b0;
        bus.i_is_ebreak = 1'b0;
        bus.i_illegal   = 1'b0;
        bus.i_is_mret   = 1'b0;
        bus.irq_ext     = 1'b0;
        bus.irq_timer   = 1'b0;
    endtask

    task automatic idle_steps(input int n);
        clear_flags();
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_csr_wr_en"},      {31'b0, bus.csr_wr_en},      32'h0);
        chk({tag, "_csr_addr"},       {20'b0, bus.csr_addr},       32'h0);
        chk({tag, "_csr_wr_data"},    bus.csr_wr_data,             32'h0);
        chk({tag, "_stall"},          {31'b0, bus.stall},          32'h0);
        chk({tag, "_flush"},          {31'b0, bus.flush},          32'h0);
        chk({tag, "_redirect_valid"}, {31'b0, bus.redirect_valid}, 32'h0);
        chk({tag, "_redirect_pc"},    bus.redirect_pc,             32'h0);
        chk({tag, "_trap_detected"},  {31'b0, bus.trap_detected},  32'h0);
    endtask

    // Monitor: pops expectations whenever the DUT presents a write, flush or redirect.
    always @(negedge clk) begin
        if (rst) begin
            while (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin
                n_cmp++; n_bad++;
                $display("FAIL missing_write: not observed, required addr 0x%03h data 0x%08h at cycle %0d", wr_q[0].addr, wr_q[0].data, wr_q[0].cyc);
                wr_q.delete(0);
            end
            while (fl_q.size() > 0 && fl_q[0].cyc < cyc) begin
                n_cmp++; n_bad++;
                $display("FAIL missing_flush: not observed, required flush at cycle %0d", fl_q[0].cyc);
                fl_q.delete(0);
            end
            while (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
                n_cmp++; n_bad++;
                $display("FAIL missing_redirect: not observed, required pc 0x%08h at cycle %0d", rd_q[0].pc, rd_q[0].cyc);
                rd_q.delete(0);
            end
            if (bus.csr_wr_en) begin
                if (wr_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_write: got addr 0x%03h data 0x%08h, required no write (cycle %0d)", bus.csr_addr, bus.csr_wr_data, cyc);
                end else begin
                    m_wr = wr_q.pop_front();
                    $display("csr write  cycle %0d addr 0x%03h data 0x%08h", cyc, bus.csr_addr, bus.csr_wr_data);
                    chk("wr_cycle", cyc, m_wr.cyc);
                    chk("wr_addr", {20'b0, bus.csr_addr}, {20'b0, m_wr.addr});
                    chk("wr_data", bus.csr_wr_data, m_wr.data);
                end
            end else begin
                chk("idle_csr_addr", {20'b0, bus.csr_addr}, 32'h0);
                chk("idle_csr_data", bus.csr_wr_data, 32'h0);
            end
            if (bus.flush) begin
                if (fl_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_flush: got flush, required none (cycle %0d)", cyc);
                end else begin
                    m_fl = fl_q.pop_front();
                    chk("flush_cycle", cyc, m_fl.cyc);
                    chk("trap_detected", {31'b0, bus.trap_detected}, {31'b0, m_fl.trap});
                end
            end else begin
                chk("trap_detected_quiet", {31'b0, bus.trap_detected}, 32'h0);
            end
            if (bus.redirect_valid) begin
                if (rd_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_redirect: got pc 0x%08h, required none (cycle %0d)", bus.redirect_pc, cyc);
                end else begin
                    m_rd = rd_q.pop_front();
                    $display("redirect   cycle %0d pc 0x%08h", cyc, bus.redirect_pc);
                    chk("redirect_cycle", cyc, m_rd.cyc);
                    chk("redirect_pc", bus.redirect_pc, m_rd.pc);
                end
            end
        end
    end

    initial begin
        clear_flags();
        bus.i_pc = 32'h0; bus.mstatus_in = 32'h0; bus.mie_in = 32'h0;
        bus.mtvec_in = 32'h0; bus.mepc_in = 32'h0;

        // Reset with a live ecall on the inputs: everything must stay at zero.
        bus.i_valid = 1'b1; bus.i_is_ecall = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        clear_flags();
        @(posedge clk); #1;
        rst = 1'b1;
        idle_steps(2);

        // ecall
        bus.i_pc = 32'h100; bus.mtvec_in = 32'h200; bus.mstatus_in = 32'h8; bus.mie_in = 32'h0;
        bus.i_valid = 1'b1; bus.i_is_ecall = 1'b1;
        step();
        idle_steps(6);

        // Exception beats a concurrent interrupt; the interrupt is taken after the sequence.
        bus.i_pc = 32'h40; bus.mtvec_in = 32'h300; bus.mstatus_in = 32'h8; bus.mie_in = 32'h800;
        bus.i_valid = 1'b1; bus.i_illegal = 1'b1; bus.i_is_ecall = 1'b1; bus.irq_ext = 1'b1;
        step();
        bus.i_illegal = 1'b0; bus.i_is_ecall = 1'b0; bus.i_pc = 32'h44;
        for (int i = 0; i < 6; i++) step();
        idle_steps(6);

        // Timer masking: global MIE, then MTIE, then both enabled.
        bus.mstatus_in = 32'h0; bus.mie_in = 32'h80; bus.i_pc = 32'h80;
        bus.i_valid = 1'b1; bus.irq_timer = 1'b1;
        step(); step();
        bus.mstatus_in = 32'h8; bus.mie_in = 32'h0;
        step(); step();
        bus.mie_in = 32'h80;
        step();
        idle_steps(6);

        // mret (illegal-wins case is exercised by the random phase)
        bus.mstatus_in = 32'h80; bus.mepc_in = 32'h104;
        bus.i_valid = 1'b1; bus.i_is_mret = 1'b1;
        step();
        idle_steps(4);

        // Interrupt and exception with mode bits 01
        bus.mtvec_in = 32'h201; bus.mstatus_in = 32'h8; bus.mie_in = 32'h800; bus.i_pc = 32'h120;
        bus.i_valid = 1'b1; bus.irq_ext = 1'b1;
        step();
        idle_steps(6);
        bus.i_valid = 1'b1; bus.i_is_ecall = 1'b1;
        step();
        idle_steps(6);

        // Reset at T+2 of an ecall: outputs clear at once and the mstatus write never happens.
        bus.mtvec_in = 32'h200; bus.mstatus_in = 32'h8; bus.i_pc = 32'h180;
        bus.i_valid = 1'b1; bus.i_is_ecall = 1'b1;
        step();
        step();
        rst = 1'b0;
        wr_q.delete(); rd_q.delete(); fl_q.delete();
        busy = 0;
        #1;
        chk_all_zero("midreset");
        @(posedge clk); #1;
        clear_flags();
        @(posedge clk); #1;
        rst = 1'b1;
        idle_steps(6);

        // Randomized traffic; mstatus only changes while idle, as the CSR file would hold it.
        for (int i = 0; i < 600; i++) begin
            bus.i_valid     = ($urandom_range(0, 3) != 0);
            bus.i_illegal   = ($urandom_range(0, 9) == 0);
            bus.i_is_ebreak = ($urandom_range(0, 9) == 0);
            bus.i_is_ecall  = ($urandom_range(0, 9) == 0);
            bus.i_is_mret   = ($urandom_range(0, 6) == 0);
            bus.irq_ext     = ($urandom_range(0, 3) == 0);
            bus.irq_timer   = ($urandom_range(0, 3) == 0);
            bus.i_pc        = $urandom & ~32'h3;
            bus.mie_in      = $urandom;
            bus.mtvec_in    = $urandom;
            if ($urandom_range(0, 1) == 1) bus.mtvec_in[1:0] = 2'b01;
            bus.mepc_in     = $urandom;
            if (busy == 0) bus.mstatus_in = $urandom;
            step();
        end
        idle_steps(8);

        chk("write_queue_drained",    wr_q.size(), 32'h0);
        chk("flush_queue_drained",    fl_q.size(), 32'h0);
        chk("redirect_queue_drained", rd_q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
